// File: rtl/sift_pkg.sv
// Shared types and helpers for the keypoint path.
// The keypoint field layout is defined only in kp_unpack.
// A keypoint word is {x[2W:W+1], y[W:1], layer[0]}.
package sift_pkg;

    localparam logic [7:0] KP_HEADER_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        KP_IDLE,
        KP_HEADER,
        KP_FETCH,
        KP_WAIT,
        KP_SEND0,
        KP_SEND1,
        KP_SEND2,
        KP_FIN
    } kp_state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       layer;
    } kp_fields_t;

    // Split a packed keypoint word (zero-extended to 17 bits) with field width w <= 8.
    function automatic kp_fields_t kp_unpack(input logic [16:0] data, input int w);
        kp_fields_t f;
        logic [16:0] mask;
        mask    = (17'd1 << w) - 17'd1;
        f.layer = data[0];
        f.y     = 8'((data >> 1) & mask);
        f.x     = 8'((data >> (w + 1)) & mask);
        return f;
    endfunction

endpackage

// File: rtl/kp_byte_mux.sv
// Keypoint holding register and output byte select with valid/ready handshake.
// In header mode the selected bytes are 0xA5, count[15:8] and count[7:0].
// byte_o is driven only while valid_o is high and is zero otherwise.
module kp_byte_mux
    import sift_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_in,
    input  logic         load_i,
    input  logic [2*W:0] data_i,
    input  logic         hdr_i,
    input  logic [1:0]   sel_i,
    input  logic [15:0]  count_i,
    input  logic         valid_i,
    input  logic         ready_i,
    output logic [7:0]   byte_o,
    output logic         valid_o,
    output logic         fire_o
);

    logic [2*W:0] hold_q, hold_d;
    kp_fields_t   f;

    assign f       = kp_unpack(17'(hold_q), W);
    assign valid_o = valid_i;
    assign fire_o  = valid_i & ready_i;

    // Load the holding register when the BRAM data is valid.
    always_comb begin
        hold_d = hold_q;
        if (load_i) begin
            hold_d = data_i;
        end
    end

    // Holding register storage.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // Select the byte presented to the sink; held constant while waiting for ready.
    always_comb begin
        byte_o = 8'h00;
        if (valid_i) begin
            if (hdr_i) begin
                case (sel_i)
                    2'd0:    byte_o = KP_HEADER_BYTE;
                    2'd1:    byte_o = count_i[15:8];
                    default: byte_o = count_i[7:0];
                endcase
            end else begin
                case (sel_i)
                    2'd0:    byte_o = f.x;
                    2'd1:    byte_o = f.y;
                    default: byte_o = {7'b0, f.layer};
                endcase
            end
        end
    end

endmodule

// File: rtl/keypoint_streamer.sv
// Streams keypoints from the octave-1 keypoint BRAM as 3 bytes each (x, y, layer).
// Define KEYPOINT_STREAM_HEADER_EN to prefix the stream with 0xA5, count[15:8], count[7:0].
//
// state     | meaning
// KP_IDLE   | waiting for start
// KP_HEADER | emitting the 3 header bytes (header build only)
// KP_FETCH  | key_read_addr presented for the current index
// KP_WAIT   | waiting out BRAM read latency, then capturing data
// KP_SEND0  | x byte
// KP_SEND1  | y byte
// KP_SEND2  | layer byte, then next index or finish
// KP_FIN    | one-cycle done pulse
module keypoint_streamer
    import sift_pkg::*;
#(
    parameter  int DIMENSION    = 64,
    parameter  int BRAM_LATENCY = 2,
    localparam int W            = $clog2(DIMENSION),
    localparam int AW           = $clog2(DIMENSION * DIMENSION)
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic          start,
    input  logic [AW:0]   key_count,
    output logic [AW-1:0] key_read_addr,
    input  logic [2*W:0]  key_data,
    output logic [7:0]    byte_out,
    output logic          byte_valid,
    input  logic          byte_ready,
    output logic          busy,
    output logic          done
);

    localparam int          WCW  = $clog2(BRAM_LATENCY + 1);
    localparam logic [AW:0] MAXK = (AW + 1)'(DIMENSION * DIMENSION);

    kp_state_t      state_q, state_d;
    logic [AW:0]    count_q, count_d;
    logic [AW:0]    idx_q, idx_d, idx_next;
    logic [AW-1:0]  addr_q, addr_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [1:0]     hsel_q, hsel_d;
    logic [AW:0]    clamped;
    logic           load, fire, valid_req, hdr;
    logic [1:0]     sel;

    assign clamped       = (key_count > MAXK) ? MAXK : key_count;
    assign key_read_addr = addr_q;
    assign busy          = (state_q != KP_IDLE) && (state_q != KP_FIN);
    assign done          = (state_q == KP_FIN);

    // Byte-producing states and which byte each one selects.
    always_comb begin
        valid_req = 1'b0;
        hdr       = 1'b0;
        sel       = 2'd0;
        case (state_q)
            KP_HEADER: begin valid_req = 1'b1; hdr = 1'b1; sel = hsel_q; end
            KP_SEND0:  begin valid_req = 1'b1; sel = 2'd0; end
            KP_SEND1:  begin valid_req = 1'b1; sel = 2'd1; end
            KP_SEND2:  begin valid_req = 1'b1; sel = 2'd2; end
            default:   ;
        endcase
    end

    // Next-state logic for the FSM, index counter and BRAM address.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        wcnt_d   = wcnt_q;
        hsel_d   = hsel_q;
        load     = 1'b0;
        idx_next = idx_q + (AW + 1)'(1);
        case (state_q)
            KP_IDLE: begin
                if (start) begin
                    count_d = clamped;
                    idx_d   = '0;
                    hsel_d  = 2'd0;
`ifdef KEYPOINT_STREAM_HEADER_EN
                    state_d = KP_HEADER;
`else
                    if (clamped == '0) begin
                        state_d = KP_FIN;
                    end else begin
                        state_d = KP_FETCH;
                        addr_d  = '0;
                    end
`endif
                end
            end
`ifdef KEYPOINT_STREAM_HEADER_EN
            KP_HEADER: begin
                if (fire) begin
                    if (hsel_q == 2'd2) begin
                        hsel_d = 2'd0;
                        if (count_q == '0) begin
                            state_d = KP_FIN;
                        end else begin
                            state_d = KP_FETCH;
                            addr_d  = '0;
                        end
                    end else begin
                        hsel_d = hsel_q + 2'd1;
                    end
                end
            end
`endif
            KP_FETCH: begin
                wcnt_d  = WCW'(BRAM_LATENCY - 1);
                state_d = KP_WAIT;
            end
            KP_WAIT: begin
                if (wcnt_q == '0) begin
                    load    = 1'b1;
                    state_d = KP_SEND0;
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                end
            end
            KP_SEND0: if (fire) state_d = KP_SEND1;
            KP_SEND1: if (fire) state_d = KP_SEND2;
            KP_SEND2: begin
                if (fire) begin
                    idx_d = idx_next;
                    if (idx_next == count_q) begin
                        state_d = KP_FIN;
                    end else begin
                        state_d = KP_FETCH;
                        addr_d  = idx_next[AW-1:0];
                    end
                end
            end
            KP_FIN:  state_d = KP_IDLE;
            default: state_d = KP_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any stream in progress.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q <= KP_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wcnt_q  <= '0;
            hsel_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            hsel_q  <= hsel_d;
        end
    end

    kp_byte_mux #(.W(W)) u_mux (
        .clk     (clk),
        .rst_in  (rst_in),
        .load_i  (load),
        .data_i  (key_data),
        .hdr_i   (hdr),
        .sel_i   (sel),
        .count_i (16'(count_q)),
        .valid_i (valid_req),
        .ready_i (byte_ready),
        .byte_o  (byte_out),
        .valid_o (byte_valid),
        .fire_o  (fire)
    );

endmodule

// File: tb/tb_keypoint_streamer.sv
// Directed bench for keypoint_streamer; expectations follow KEYPOINT_STREAM_HEADER_EN.
module tb_keypoint_streamer;

    localparam int W  = 6;
    localparam int AW = 12;

`ifdef KEYPOINT_STREAM_HEADER_EN
    localparam int HB = 3;
`else
    localparam int HB = 0;
`endif

    typedef struct packed {
        logic [AW:0]        kc;
        logic               rnd;
        logic [7:0]         nb;
        logic [11:0]        addr;
        logic [0:11][7:0]   exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_in, start, byte_ready;
    logic [AW:0]   key_count;
    logic [AW-1:0] key_read_addr;
    logic [2*W:0]  key_data, d1;
    logic [7:0]    byte_out;
    logic          byte_valid, busy, done;

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         rnd_mode = 1'b0;
    logic [7:0] acc_q[$];
    int         done_cnt = 0;
    logic       hold_prev = 1'b0;
    logic [7:0] byte_prev = 8'h00;
    vec_t       vecs[6];
    bit         ok;

    always #5 clk = ~clk;

    keypoint_streamer #(.DIMENSION(64), .BRAM_LATENCY(2)) dut (
        .clk           (clk),
        .rst_in        (rst_in),
        .start         (start),
        .key_count     (key_count),
        .key_read_addr (key_read_addr),
        .key_data      (key_data),
        .byte_out      (byte_out),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .busy          (busy),
        .done          (done)
    );

    function automatic logic [2*W:0] bram_f(input logic [AW-1:0] a);
        case (a)
            12'd0:   return {6'd5, 6'd9, 1'b0};
            12'd1:   return {6'd63, 6'd0, 1'b1};
            12'd2:   return {6'd0, 6'd63, 1'b0};
            default: return {a[5:0], a[11:6], a[0]};
        endcase
    endfunction

    // Two-cycle BRAM model: address register then output register.
    always @(posedge clk) begin
        d1       <= bram_f(key_read_addr);
        key_data <= d1;
    end

    always @(posedge clk) begin
        #1;
        if (rnd_mode) byte_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte monitor: records accepted bytes and checks hold stability.
    always @(negedge clk) begin
        if (hold_prev) begin
            check("hold_valid", 32'(byte_valid), 32'd1);
            check("hold_byte", 32'(byte_out), 32'(byte_prev));
        end
        if (!rst_in && byte_valid && byte_ready) acc_q.push_back(byte_out);
        if (done) done_cnt++;
        hold_prev = !rst_in && byte_valid && !byte_ready;
        byte_prev = byte_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [AW:0] kc, input logic rnd, input logic [11:0] addr);
        vec_t v;
        logic [0:8][7:0] p;
        int n;
        p = {8'h05, 8'h09, 8'h00, 8'h3F, 8'h00, 8'h01, 8'h00, 8'h3F, 8'h00};
        v = '0;
        v.kc = kc;
        v.rnd = rnd;
        v.addr = addr;
        n = 0;
`ifdef KEYPOINT_STREAM_HEADER_EN
        v.exp[0] = 8'hA5;
        v.exp[1] = 8'h00;
        v.exp[2] = 8'(kc);
        n = 3;
`endif
        for (int i = 0; i < 3 * int'(kc); i++) begin
            v.exp[n] = p[i];
            n++;
        end
        v.nb = 8'(n);
        return v;
    endfunction

    task automatic run(input logic [AW:0] kc, input bit rnd, input int restart_at, output bit got);
        got = 1'b0;
        acc_q.delete();
        done_cnt = 0;
        rnd_mode = rnd;
        if (!rnd) byte_ready = 1'b1;
        tick();
        start = 1'b1;
        key_count = kc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
            start = (i == restart_at);
        end
        tick();
        start = 1'b0;
        rnd_mode = 1'b0;
        byte_ready = 1'b1;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no done pulse for key_count %0d", kc);
        end
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("done_count", 32'(done_cnt), 32'd1);
    endtask

    task automatic compare_vec(input vec_t v, input string tag);
        check({tag, "_nbytes"}, 32'(acc_q.size()), 32'(v.nb));
        for (int j = 0; j < int'(v.nb); j++) begin
            if (j < acc_q.size()) check({tag, "_byte"}, 32'(acc_q[j]), 32'(v.exp[j]));
        end
        check({tag, "_addr"}, 32'(key_read_addr), 32'(v.addr));
    endtask

    initial begin
        vecs[0] = mk(13'd3, 1'b0, 12'd2);
        vecs[1] = mk(13'd3, 1'b1, 12'd2);
        vecs[2] = mk(13'd0, 1'b0, 12'd2);
        vecs[3] = mk(13'd1, 1'b1, 12'd0);
        vecs[4] = mk(13'd2, 1'b0, 12'd1);
        vecs[5] = mk(13'd0, 1'b1, 12'd1);

        rst_in = 1'b1;
        start = 1'b0;
        key_count = '0;
        byte_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_byte", 32'(byte_out), 32'd0);
        check("rst_addr", 32'(key_read_addr), 32'd0);
        tick();
        rst_in = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run(vecs[v].kc, vecs[v].rnd, -1, ok);
            compare_vec(vecs[v], $sformatf("vec%0d", v));
        end

        // Reset during SEND1 of the second keypoint, then replay from keypoint 0.
        acc_q.delete();
        byte_ready = 1'b1;
        tick();
        start = 1'b1;
        key_count = 13'd3;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (acc_q.size() == HB + 4) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("abort_reached", 32'(ok), 32'd1);
        byte_ready = 1'b0;
        rst_in = 1'b1;
        @(negedge clk);
        check("abort_pre_valid", 32'(byte_valid), 32'd1);
        check("abort_pre_byte", 32'(byte_out), 32'h00);
        tick();
        rst_in = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(byte_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        run(13'd3, 1'b0, -1, ok);
        compare_vec(vecs[0], "replay");

        // Oversized count with a second start mid-stream.
        run(13'd5000, 1'b0, 50, ok);
        check("big_nbytes", 32'(acc_q.size()), 32'(HB + 3 * 4096));
        if (acc_q.size() >= 3) begin
            check("big_last_x", 32'(acc_q[acc_q.size() - 3]), 32'h3F);
            check("big_last_y", 32'(acc_q[acc_q.size() - 2]), 32'h3F);
            check("big_last_l", 32'(acc_q[acc_q.size() - 1]), 32'h01);
        end
`ifdef KEYPOINT_STREAM_HEADER_EN
        if (acc_q.size() >= 3) begin
            check("big_hdr0", 32'(acc_q[0]), 32'hA5);
            check("big_hdr1", 32'(acc_q[1]), 32'h10);
            check("big_hdr2", 32'(acc_q[2]), 32'h00);
        end
`endif
        check("big_addr", 32'(key_read_addr), 32'd4095);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
